lab1_button_conditioner: RTL and testbench

//  Upstream stage for the lab1 ALU top level: takes raw active-low board pushbuttons and
//  raw 4-bit switch operands and produces clean, stable drive for the ALU's
//  not_LEFT_pushbutton / not_RIGHT_pushbutton / A / B inputs.
//  - Synchronises and debounces each button.
//  - Latches the selected operation (AND on LEFT, ADD on RIGHT) so the button need not be held.
//  - Captures the operands at each press.

---
 rtl/lab1_pkg.sv | 26 ++
 rtl/lab1_button_conditioner_if.sv | 27 ++
 rtl/lab1_button_conditioner_debouncer.sv | 52 +++++
 rtl/lab1_button_conditioner.sv | 110 +++++++++++
 tb/tb_lab1_button_conditioner.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/lab1_pkg.sv
// Shared definitions for the lab1 front end: operation mode encoding,
// default sizing and the mode-to-pushbutton drive mapping.
package lab1_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_AND  = 2'b01,
    MODE_ADD  = 2'b10
  } mode_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int WIDTH_DEF           = 4;
  localparam int CNT_W_DEF           = 8;

  // Returns {not_LEFT_pushbutton, not_RIGHT_pushbutton}; never both low.
  function automatic logic [1:0] pushbutton_drive(input mode_e mode);
    logic [1:0] drive;
    case (mode)
      MODE_AND: drive = 2'b01;
      MODE_ADD: drive = 2'b10;
      default:  drive = 2'b11;
    endcase
    return drive;
  endfunction

endpackage

// File: rtl/lab1_button_conditioner_if.sv
// Board-side bundle of the lab1 front end: raw buttons and switches in,
// clean ALU drive out.
interface lab1_button_conditioner_if
  #(parameter int WIDTH = lab1_pkg::WIDTH_DEF,
    parameter int CNT_W = lab1_pkg::CNT_W_DEF);

  logic             not_LEFT_raw;
  logic             not_RIGHT_raw;
  logic [WIDTH-1:0] sw_A;
  logic [WIDTH-1:0] sw_B;
  logic             not_LEFT_pushbutton;
  logic             not_RIGHT_pushbutton;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [CNT_W-1:0] op_count;

  modport master (
    output not_LEFT_raw, not_RIGHT_raw, sw_A, sw_B,
    input  not_LEFT_pushbutton, not_RIGHT_pushbutton, A, B, op_count
  );

  modport slave (
    input  not_LEFT_raw, not_RIGHT_raw, sw_A, sw_B,
    output not_LEFT_pushbutton, not_RIGHT_pushbutton, A, B, op_count
  );

endinterface

// File: rtl/lab1_button_conditioner_debouncer.sv
// One active-low button: two-flop synchroniser, stability counter,
// debounced level and a one-cycle registered press pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = lab1_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          press_r;
  logic          differ_s;
  logic          flip_s;

  assign differ_s = (sync2_r != level_r);
  // The pulse is registered on the same edge the level flips, so the
  // consumer acts one edge later.
  assign flip_s   = differ_s && (cnt_r == LAST_CNT);
  assign press    = press_r;

  // Synchroniser, stability counter, debounced level and press pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
      cnt_r   <= {CW{1'b0}};
      press_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      press_r <= flip_s && !sync2_r;
      if (flip_s) begin
        level_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else if (differ_s) begin
        cnt_r   <= cnt_r + CW'(1);
      end else begin
        cnt_r   <= {CW{1'b0}};
      end
    end
  end

endmodule

// File: rtl/lab1_button_conditioner.sv
// Front end for the lab1 ALU: debounced buttons select a latched operation,
// and operands are captured from the switches at every accepted press.
module lab1_button_conditioner
  import lab1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int WIDTH           = WIDTH_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  lab1_button_conditioner_if.slave   bus
);

  logic             left_press_s;
  logic             right_press_s;
  logic             event_s;
  mode_e            mode_r;
  mode_e            mode_nxt_s;
  logic [1:0]       drive_nxt_s;
  logic             not_left_r;
  logic             not_right_r;
  logic [WIDTH-1:0] sw_a_sync1_r;
  logic [WIDTH-1:0] sw_a_sync2_r;
  logic [WIDTH-1:0] sw_b_sync1_r;
  logic [WIDTH-1:0] sw_b_sync2_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] cnt_r;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (bus.not_LEFT_raw),
    .press   (left_press_s)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (bus.not_RIGHT_raw),
    .press   (right_press_s)
  );

  assign event_s = left_press_s || right_press_s;

  // Mode next-state: LEFT has priority over a simultaneous RIGHT press.
  always_comb begin
    mode_nxt_s = MODE_IDLE;
    if (left_press_s) begin
      mode_nxt_s = MODE_AND;
    end else if (right_press_s) begin
      mode_nxt_s = MODE_ADD;
    end else begin
      case (mode_r)
        MODE_AND: mode_nxt_s = MODE_AND;
        MODE_ADD: mode_nxt_s = MODE_ADD;
        default:  mode_nxt_s = MODE_IDLE;
      endcase
    end
    drive_nxt_s = pushbutton_drive(mode_nxt_s);
  end

  // Mode state and registered pushbutton drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r      <= MODE_IDLE;
      not_left_r  <= 1'b1;
      not_right_r <= 1'b1;
    end else begin
      mode_r      <= mode_nxt_s;
      not_left_r  <= drive_nxt_s[1];
      not_right_r <= drive_nxt_s[0];
    end
  end

  // Switch synchronisers, operand capture and press counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_a_sync1_r <= {WIDTH{1'b0}};
      sw_a_sync2_r <= {WIDTH{1'b0}};
      sw_b_sync1_r <= {WIDTH{1'b0}};
      sw_b_sync2_r <= {WIDTH{1'b0}};
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      sw_a_sync1_r <= bus.sw_A;
      sw_a_sync2_r <= sw_a_sync1_r;
      sw_b_sync1_r <= bus.sw_B;
      sw_b_sync2_r <= sw_b_sync1_r;
      if (event_s) begin
        a_r   <= sw_a_sync2_r;
        b_r   <= sw_b_sync2_r;
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        a_r   <= a_r;
        b_r   <= b_r;
        cnt_r <= cnt_r;
      end
    end
  end

  assign bus.not_LEFT_pushbutton  = not_left_r;
  assign bus.not_RIGHT_pushbutton = not_right_r;
  assign bus.A                    = a_r;
  assign bus.B                    = b_r;
  assign bus.op_count             = cnt_r;

endmodule

// File: tb/tb_lab1_button_conditioner.sv
// Scoreboard bench for lab1_button_conditioner: stimulus queues expected
// outputs, a negedge monitor compares on every output change or probe request.
module tb_lab1_button_conditioner;
  import lab1_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;

  typedef struct {
    string       name;
    int          edge_no;
    logic [17:0] vec;
    logic [3:0]  alu;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  exp_t ev_q[$];
  exp_t st_q[$];
  logic [7:0] exp_cnt;

  lab1_button_conditioner_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  lab1_button_conditioner #(.DEBOUNCE_CYCLES(4), .WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] pack(input logic nl, input logic nr,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic [7:0] c);
    return {nl, nr, a, b, c};
  endfunction

  function automatic logic [17:0] act_vec();
    return {bus.not_LEFT_pushbutton, bus.not_RIGHT_pushbutton, bus.A, bus.B, bus.op_count};
  endfunction

  // Behavioural lab1 ALU fed by the conditioner outputs.
  function automatic logic [3:0] alu_result();
    if (!bus.not_LEFT_pushbutton)       return bus.A & bus.B;
    else if (!bus.not_RIGHT_pushbutton) return bus.A + bus.B;
    else                                return 4'b0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_steady(input string name, input logic [17:0] vec, input logic [3:0] alu);
    exp_t e;
    e.name = name; e.edge_no = -1; e.vec = vec; e.alu = alu;
    st_q.push_back(e);
  endtask

  // Drive a press of low_cycles on the selected buttons, then release and settle.
  task automatic press(input string name, input logic l, input logic r, input int low_cycles,
                       input logic [3:0] sa, input logic [3:0] sb, input logic expect_ev,
                       input logic [17:0] vec, input logic [3:0] alu);
    exp_t e;
    @(negedge clk);
    bus.sw_A = sa;
    bus.sw_B = sb;
    if (expect_ev) begin
      e.name = name; e.edge_no = cyc + 7; e.vec = vec; e.alu = alu;
      ev_q.push_back(e);
    end
    if (l) bus.not_LEFT_raw  = 1'b0;
    if (r) bus.not_RIGHT_raw = 1'b0;
    repeat (low_cycles) @(negedge clk);
    bus.not_LEFT_raw  = 1'b1;
    bus.not_RIGHT_raw = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Monitor: every output change must match the next queued event.
  initial begin
    logic [17:0] prev_vec;
    logic [17:0] cur;
    exp_t        e;
    prev_vec = 18'h0;
    forever begin
      @(negedge clk);
      cur = act_vec();
      if (!reset_n) begin
        prev_vec = cur;
      end else if (cur !== prev_vec) begin
        if (ev_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got %0h expected no change from %0h", cur, prev_vec);
        end else begin
          e = ev_q.pop_front();
          check({e.name, "_out"}, 32'(cur), 32'(e.vec));
          check({e.name, "_latency"}, cyc, e.edge_no);
          check({e.name, "_alu"}, 32'(alu_result()), 32'(e.alu));
        end
        prev_vec = cur;
      end else if (st_q.size() != 0) begin
        e = st_q.pop_front();
        check({e.name, "_out"}, 32'(cur), 32'(e.vec));
        check({e.name, "_alu"}, 32'(alu_result()), 32'(e.alu));
      end
    end
  end

  // Asynchronous reset must clear the outputs without waiting for a clock.
  initial begin
    forever begin
      @(negedge reset_n);
      #1;
      check("async_reset", 32'(act_vec()), 32'(pack(1'b1, 1'b1, 4'h0, 4'h0, 8'h00)));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    logic l;
    logic [3:0] sa;
    logic [3:0] sb;
    logic [7:0] iv;
    bus.not_LEFT_raw  = 1'b1;
    bus.not_RIGHT_raw = 1'b1;
    bus.sw_A          = 4'h0;
    bus.sw_B          = 4'h0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 1: idle after reset
    repeat (20) @(negedge clk);
    expect_steady("t1_reset", pack(1'b1, 1'b1, 4'h0, 4'h0, 8'd0), 4'b0000);

    // 2: LEFT press selects AND, holds after release
    press("t2_left", 1'b1, 1'b0, 7, 4'b1100, 4'b1010, 1'b1,
          pack(1'b0, 1'b1, 4'b1100, 4'b1010, 8'd1), 4'b1000);
    expect_steady("t2_hold", pack(1'b0, 1'b1, 4'b1100, 4'b1010, 8'd1), 4'b1000);

    // 3: short RIGHT glitch rejected, then real RIGHT press selects ADD
    press("t3_glitch", 1'b0, 1'b1, 3, 4'b0001, 4'b0011, 1'b0, 18'h0, 4'h0);
    expect_steady("t3_glitch", pack(1'b0, 1'b1, 4'b1100, 4'b1010, 8'd1), 4'b1000);
    press("t3_right", 1'b0, 1'b1, 8, 4'b0001, 4'b0011, 1'b1,
          pack(1'b1, 1'b0, 4'b0001, 4'b0011, 8'd2), 4'b0100);

    // 4: switch change without press is invisible
    @(negedge clk);
    bus.sw_A = 4'b1111;
    repeat (10) @(negedge clk);
    expect_steady("t4_noprs", pack(1'b1, 1'b0, 4'b0001, 4'b0011, 8'd2), 4'b0100);

    // 5: simultaneous press -> AND, one count
    press("t5_both", 1'b1, 1'b1, 7, 4'b1111, 4'b0011, 1'b1,
          pack(1'b0, 1'b1, 4'b1111, 4'b0011, 8'd3), 4'b0011);

    // 6a: ADD mode, then reset while LEFT is mid-debounce
    press("t6_right", 1'b0, 1'b1, 7, 4'b0101, 4'b0110, 1'b1,
          pack(1'b1, 1'b0, 4'b0101, 4'b0110, 8'd4), 4'b1011);
    @(negedge clk);
    bus.not_LEFT_raw = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.not_LEFT_raw = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    expect_steady("t6_after_rst", pack(1'b1, 1'b1, 4'h0, 4'h0, 8'd0), 4'b0000);

    // 6b: 256 presses wrap op_count to 0
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      l  = ~iv[0];
      sa = iv[3:0];
      sb = iv[7:4];
      exp_cnt = exp_cnt + 8'd1;
      press("t6_wrap", l, ~l, 5, sa, sb, 1'b1,
            pack(~l, l, sa, sb, exp_cnt),
            l ? (sa & sb) : (sa + sb));
    end
    expect_steady("t6_wrapped", pack(1'b1, 1'b0, 4'hF, 4'hF, 8'h00), 4'b1110);

    wait_cnt = 0;
    while ((ev_q.size() != 0 || st_q.size() != 0) && wait_cnt < 300) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (ev_q.size() != 0 || st_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", ev_q.size() + st_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
